// File: rtl/gcd_operand_sequencer_pkg.sv
// Shared definitions for the GCD operand sequencer: state encoding, operand
// width and the rule for jobs the engine must never see.
package gcd_operand_sequencer_pkg;

  localparam int OPW = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POP_A   = 3'd1;
  localparam logic [2:0] S_POP_B   = 3'd2;
  localparam logic [2:0] S_ENG_RST = 3'd3;
  localparam logic [2:0] S_PRES_A  = 3'd4;
  localparam logic [2:0] S_PRES_B  = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;
  localparam logic [2:0] S_OUT     = 3'd7;

  // The engine never terminates with a zero operand; gcd(x,0)=x is answered locally.
  function automatic logic gcd_trivial(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/gcd_operand_fifo.sv
// Small synchronous operand FIFO with a registered not-full flag and a
// combinational head, so a pop cycle can capture the byte it removes.
module gcd_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     not_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_full_q, not_full_d;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] wr_en;

  assign do_pop  = pop && (count_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_q == AW'(gi));
  end

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    not_full_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_q[i] <= wdata;
    end
  end

  assign rdata    = mem_q[rd_ptr_q];
  assign not_full = not_full_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs from a byte FIFO into the GCD engine, collects the
// result (or a timeout) and hands it downstream over valid/ready.
module gcd_operand_sequencer
  import gcd_operand_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int RST_CYCLES  = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       gcd_rst,
  output logic [7:0] gcd_a,
  output logic [7:0] gcd_b,
  output logic       gcd_a_available,
  output logic       gcd_b_available,
  input  logic [7:0] gcd_out,
  input  logic       gcd_out_ready,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_timeout,
  output logic       busy
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int MAX_RH  = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX = (TIMEOUT > MAX_RH) ? TIMEOUT : MAX_RH;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  logic [OPW-1:0]  fifo_head;
  logic            fifo_not_full, fifo_empty, fifo_pop, fifo_push;
  logic [CW-1:0]   fifo_count;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [OPW-1:0]  reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [OPW-1:0]  res_data_q, res_data_d;
  logic            res_timeout_q, res_timeout_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic            gcd_rst_q, gcd_rst_d;
  logic            a_av_q, a_av_d, b_av_q, b_av_d;
  logic [OPW-1:0]  gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;

  assign fifo_push = in_valid && fifo_not_full;

  gcd_operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OPW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .wdata    (in_data),
    .rdata    (fifo_head),
    .not_full (fifo_not_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      reg_a_q       <= '0;
      reg_b_q       <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      gcd_rst_q     <= 1'b1;
      a_av_q        <= 1'b0;
      b_av_q        <= 1'b0;
      gcd_a_q       <= '0;
      gcd_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reg_a_q       <= reg_a_d;
      reg_b_q       <= reg_b_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      gcd_rst_q     <= gcd_rst_d;
      a_av_q        <= a_av_d;
      b_av_q        <= b_av_d;
      gcd_a_q       <= gcd_a_d;
      gcd_b_q       <= gcd_b_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    reg_a_d       = reg_a_q;
    reg_b_d       = reg_b_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    fifo_pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count >= CW'(2)) state_d = S_POP_A;
      end
      S_POP_A: begin
        fifo_pop = !fifo_empty;
        reg_a_d  = fifo_head;
        state_d  = S_POP_B;
      end
      S_POP_B: begin
        fifo_pop = !fifo_empty;
        reg_b_d  = fifo_head;
        cnt_d    = '0;
        if (gcd_trivial(reg_a_q, fifo_head)) begin
          res_data_d    = reg_a_q | fifo_head;
          res_timeout_d = 1'b0;
          state_d       = S_OUT;
        end else begin
          state_d = S_ENG_RST;
        end
      end
      S_ENG_RST: begin
        if (cnt_q == CNTW'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_PRES_A;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_PRES_A, S_PRES_B: begin
        if (cnt_q == CNTW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == S_PRES_A) ? S_PRES_B : S_WAIT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_WAIT: begin
        // A result in the last allowed cycle still wins over the timeout.
        if (gcd_out_ready) begin
          res_data_d    = gcd_out;
          res_timeout_d = 1'b0;
          cnt_d         = '0;
          state_d       = S_OUT;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_OUT;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_OUT: begin
        if (res_valid_q && res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flops are computed from the next state so they line up with state_q.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    gcd_rst_d   = (state_d == S_ENG_RST);
    res_valid_d = (state_d == S_OUT);
    a_av_d      = (state_d == S_PRES_A) || (state_d == S_PRES_B) || (state_d == S_WAIT) ||
                  ((state_d == S_OUT) && a_av_q);
    b_av_d      = (state_d == S_PRES_B) || (state_d == S_WAIT) ||
                  ((state_d == S_OUT) && b_av_q);
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    if (state_d == S_ENG_RST) begin
      gcd_a_d = reg_a_d;
      gcd_b_d = reg_b_d;
    end
  end

  assign in_ready        = fifo_not_full;
  assign gcd_rst         = gcd_rst_q;
  assign gcd_a           = gcd_a_q;
  assign gcd_b           = gcd_b_q;
  assign gcd_a_available = a_av_q;
  assign gcd_b_available = b_av_q;
  assign res_data        = res_data_q;
  assign res_valid       = res_valid_q;
  assign res_timeout     = res_timeout_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a behavioural GCD engine
// whose latency can be set or made to never finish.
module tb_gcd_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       gcd_rst;
  logic [7:0] gcd_a, gcd_b;
  logic       gcd_a_available, gcd_b_available;
  logic [7:0] gcd_out;
  logic       gcd_out_ready;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       res_timeout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int rst_rise_cyc = 0, rst_fall_cyc = 0, a_rise_cyc = 0, b_rise_cyc = 0, rst_rise_cnt = 0;
  logic prev_grst = 1'b0, prev_a = 1'b0, prev_b = 1'b0;
  int res_cyc = 0;

  int   eng_delay = 10;
  logic engine_dead = 1'b0;
  int   eng_cnt = 0;

  always #5 clk = ~clk;

  gcd_operand_sequencer #(
    .FIFO_DEPTH  (4),
    .RST_CYCLES  (2),
    .HOLD_CYCLES (2),
    .TIMEOUT     (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .gcd_rst         (gcd_rst),
    .gcd_a           (gcd_a),
    .gcd_b           (gcd_b),
    .gcd_a_available (gcd_a_available),
    .gcd_b_available (gcd_b_available),
    .gcd_out         (gcd_out),
    .gcd_out_ready   (gcd_out_ready),
    .res_data        (res_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_timeout     (res_timeout),
    .busy            (busy)
  );

  function automatic logic [7:0] euclid(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine model: starts counting once both operands are presented.
  always @(posedge clk) begin
    if (gcd_rst === 1'b1) begin
      eng_cnt       <= 0;
      gcd_out_ready <= 1'b0;
      gcd_out       <= 8'd0;
    end else if (gcd_a_available && gcd_b_available && !engine_dead) begin
      if (eng_cnt >= eng_delay) begin
        gcd_out_ready <= 1'b1;
        gcd_out       <= euclid(gcd_a, gcd_b);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_grst <= gcd_rst;
    prev_a    <= gcd_a_available;
    prev_b    <= gcd_b_available;
    if (gcd_rst === 1'b1 && prev_grst === 1'b0) begin
      rst_rise_cyc <= cyc;
      rst_rise_cnt <= rst_rise_cnt + 1;
    end
    if (gcd_rst === 1'b0 && prev_grst === 1'b1) rst_fall_cyc <= cyc;
    if (gcd_a_available === 1'b1 && prev_a === 1'b0) a_rise_cyc <= cyc;
    if (gcd_b_available === 1'b1 && prev_b === 1'b0) b_rise_cyc <= cyc;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int exp_d, input int exp_to);
    int n = 0;
    res_ready = 1'b1;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, int'(res_valid), 1);
    if (res_valid) begin
      res_cyc = cyc;
      $display("result %s: data=%0d timeout=%0d", tag, res_data, res_timeout);
      check({tag, "_data"}, int'(res_data), exp_d);
      check({tag, "_timeout"}, int'(res_timeout), exp_to);
      @(negedge clk);
      check({tag, "_single"}, int'(res_valid), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int busy_cnt;
    int n;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_gcd_rst", int'(gcd_rst), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_a_av", int'(gcd_a_available), 0);
    check("rst_res_data", int'(res_data), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);
    check("rel_gcd_rst", int'(gcd_rst), 0);

    // Basic engine job.
    res_ready = 1'b1;
    push_byte(8'd48);
    push_byte(8'd18);
    get_result("j48_18", 6, 0);
    check("j1_rst_len", rst_fall_cyc - rst_rise_cyc, 2);
    check("j1_a_after_rst", a_rise_cyc - rst_fall_cyc, 0);
    check("j1_b_after_a", b_rise_cyc - a_rise_cyc, 2);

    // Zero bypass never touches the engine.
    n0 = rst_rise_cnt;
    push_byte(8'd0);
    push_byte(8'd35);
    get_result("j0_35", 35, 0);
    push_byte(8'd0);
    push_byte(8'd0);
    get_result("j0_0", 0, 0);
    check("bypass_no_eng_rst", rst_rise_cnt, n0);

    // Backpressure fills the FIFO.
    eng_delay = 3;
    res_ready = 1'b0;
    push_byte(8'd20);
    push_byte(8'd5);
    push_byte(8'd9);
    push_byte(8'd6);
    push_byte(8'd13);
    check("bp_ready_before_full", int'(in_ready), 1);
    push_byte(8'd13);
    check("bp_ready_full", int'(in_ready), 0);
    repeat (30) @(negedge clk);
    check("bp_held_valid", int'(res_valid), 1);
    check("bp_still_full", int'(in_ready), 0);
    fork
      begin
        push_byte(8'd7);
        push_byte(8'd1);
      end
      begin
        get_result("j20_5", 5, 0);
        get_result("j9_6", 3, 0);
        get_result("j13_13", 13, 0);
        get_result("j7_1", 1, 0);
      end
    join

    // Engine never answers.
    engine_dead = 1'b1;
    push_byte(8'd10);
    push_byte(8'd4);
    get_result("jtimeout", 0, 1);
    check("timeout_latency", res_cyc - b_rise_cyc, 18);
    engine_dead = 1'b0;
    push_byte(8'd14);
    push_byte(8'd21);
    get_result("j14_21", 7, 0);

    // Reset while waiting on the engine.
    engine_dead = 1'b1;
    push_byte(8'd100);
    push_byte(8'd75);
    n = 0;
    while (!gcd_b_available && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_b_av", int'(gcd_b_available), 1);
    repeat (4) @(negedge clk);
    push_byte(8'd7);
    rst = 1'b0;
    @(negedge clk);
    check("mid_busy", int'(busy), 0);
    check("mid_res_valid", int'(res_valid), 0);
    check("mid_gcd_rst", int'(gcd_rst), 1);
    check("mid_a_av", int'(gcd_a_available), 0);
    rst = 1'b1;
    engine_dead = 1'b0;
    @(negedge clk);
    push_byte(8'd12);
    push_byte(8'd8);
    get_result("j12_8", 4, 0);

    // A single byte waits forever.
    push_byte(8'd9);
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("single_idle", busy_cnt, 0);
    push_byte(8'd3);
    get_result("j9_3", 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
- Upstream feeder and result collector for the GCD engine (a/b + a_available/b_available in; out + out_ready back).
- Accepts a byte stream of operands over valid/ready and buffers them in a small FIFO.
- Pairs consecutive bytes as (a, b), resets the engine, presents a then b, waits for out_ready, and returns the GCD over valid/ready.
- Shortcuts zero operands, which the engine cannot terminate on, and flags a timeout if the engine never completes.

Parameters:
- FIFO_DEPTH, 4: operand FIFO entries (bytes); power of two, at least 2.
- RST_CYCLES, 2: cycles gcd_rst is held high per job.
- HOLD_CYCLES, 2: cycles each operand is presented before advancing.
- TIMEOUT, 1024: maximum cycles in WAIT before aborting.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full.
- gcd_rst  out  1  active-high reset to engine.
- gcd_a  out  8  operand a to engine.
- gcd_b  out  8  operand b to engine.
- gcd_a_available  out  1  a valid on gcd_a.
- gcd_b_available  out  1  b valid on gcd_b.
- gcd_out  in  8  engine result.
- gcd_out_ready  in  1  engine result valid.
- res_data  out  8  GCD result (0 on timeout).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_timeout  out  1  qualifies res_data; 1 means the job was aborted.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; FSM to IDLE; counters cleared.
  - All outputs 0, except gcd_rst=1 (engine is held in reset while this block is in reset).
  - Reset mid-job abandons the job; the pending result is discarded.
- FIFO:
  - Push when in_valid && in_ready. Pop is internal.
  - Push and pop in the same cycle are both honoured, including when full.
  - in_ready = !full, registered from count.
  - Pointers wrap modulo FIFO_DEPTH; count has width clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, POP_A, POP_B, ENG_RST, PRES_A, PRES_B, WAIT, OUT.
  - IDLE: when count>=2, go to POP_A. A single leftover byte waits indefinitely.
  - POP_A / POP_B: one cycle each; the FIFO head is popped into reg_a / reg_b.
  - After POP_B:
    - if reg_a==0 or the popped b==0: res_data = reg_a|b (gcd(x,0)=x, gcd(0,0)=0), go to OUT, engine untouched;
    - else go to ENG_RST.
  - ENG_RST: gcd_rst=1 for RST_CYCLES cycles; gcd_a=reg_a and gcd_b=reg_b driven from this state onward.
  - PRES_A: gcd_rst=0, gcd_a_available=1 for HOLD_CYCLES.
  - PRES_B: gcd_b_available=1 for HOLD_CYCLES; gcd_a_available stays 1.
  - WAIT:
    - both availables remain 1; cycle counter increments;
    - on gcd_out_ready=1: capture gcd_out into res_data, res_timeout=0, go to OUT;
    - if the counter reaches TIMEOUT-1 with no out_ready: res_data=0, res_timeout=1, go to OUT.
  - OUT:
    - res_valid=1, data stable until res_ready;
    - on res_valid && res_ready, go to IDLE (res_valid=0 next cycle);
    - the availables drop to 0 on leaving OUT.
- Outputs are registered; gcd_out_ready arriving during PRES_A/PRES_B is ignored.
- Minimum latency, last byte accepted to res_valid, for a non-zero job: 2 (pops) + RST_CYCLES + 2×HOLD_CYCLES + engine time + 1.
- Zero-bypass latency: 3 cycles after the second byte is at the FIFO head.
- Backpressure on res_ready holds the FSM in OUT; the FIFO still accepts input until full.

Decomposition:
- Shared package:
  - FSM state encoding (3-bit localparams);
  - operand width constant (8);
  - the zero-bypass rule as a function gcd_trivial(a,b).
- One sub-module: gcd_operand_fifo (synchronous FIFO with the same clk and active-low synchronous rst, parameter DEPTH, push/pop/full/empty/count).

Test Plan:
- Push 48, 18; res_ready=1; engine model returns 6 after 10 cycles.
  - Required: gcd_rst high 2 cycles, then a_available, then b_available.
  - Required: res_data=6, res_timeout=0, single-cycle res_valid.
- Push 0, 35 → res_data=35 with gcd_rst never pulsed after reset release. Push 0, 0 → res_data=0.
- Push 8 bytes (20,5, 9,6, 13,13, 7,1) with res_ready=0.
  - Required: in_ready falls once 4 are buffered plus the job in flight.
  - Then, with res_ready=1, results 5, 3, 13, 1 arrive in order.
- Engine model never raises out_ready, TIMEOUT=16 → res_valid with res_data=0, res_timeout=1 exactly 16 cycles after entering WAIT; next job proceeds normally.
- Assert rst=0 during WAIT of job (100, 75).
  - Required: next cycle busy=0, res_valid=0, FIFO empty, gcd_rst=1.
  - After release, push 12, 8 → res_data=4.
- Push exactly one byte (9) → busy stays 0 for 50 cycles; push 3 → res_data=3.
